// File: rtl/phase_pkg.sv
// Shared definitions for the four-phase strobe deserialiser: FSM state type,
// default word width and phase-sequencing helpers.
package phase_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_PH2,
    ST_PH3,
    ST_PH4
  } phase_state_e;

  function automatic phase_state_e next_phase(phase_state_e s);
    case (s)
      ST_PH1:  return ST_PH2;
      ST_PH2:  return ST_PH3;
      ST_PH3:  return ST_PH4;
      default: return ST_PH1;
    endcase
  endfunction

  // One-hot {p4,p3,p2,p1} strobe whose rise enters phase s.
  function automatic logic [3:0] phase_strobe(phase_state_e s);
    case (s)
      ST_PH1:  return 4'b0001;
      ST_PH2:  return 4'b0010;
      ST_PH3:  return 4'b0100;
      ST_PH4:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/phase_shift_reg_if.sv
// Strobe/serial input and word handshake bundle for phase_shift_reg.
// master = upstream divider plus consumer side, slave = the deserialiser.
interface phase_shift_reg_if #(
  parameter int unsigned WIDTH = phase_pkg::WIDTH_DEFAULT
);
  logic             p1;
  logic             p2;
  logic             p3;
  logic             p4;
  logic             din;
  logic             word_ready;
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             phase_err;
  logic             overrun;

  modport master (
    output p1, p2, p3, p4, din, word_ready,
    input  word_valid, word_data, phase_err, overrun
  );

  modport slave (
    input  p1, p2, p3, p4, din, word_ready,
    output word_valid, word_data, phase_err, overrun
  );
endinterface

// File: rtl/phase_edge_det.sv
// Strobe sampling flop plus rise detector. A rise is only reported once the
// strobe has been seen low after reset release, so a level held across reset is not an edge.
module phase_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic rise_o
);
  logic sample_q;
  logic prev_q;
  logic live_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
      live_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sample_q <= strobe_i;
      prev_q   <= sample_q;
      live_q   <= 1'b1;
      // live_q marks sample_q as a real sample rather than its reset value
      if (live_q && !sample_q) armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & sample_q & ~prev_q;
endmodule

// File: rtl/phase_shift_reg.sv
// Four-phase strobe serial-to-parallel converter with valid/ready word output.
// Build macro PHASE_ORDER_CHK_EN enables the phase-order FSM and phase_err.
module phase_shift_reg
  import phase_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  phase_shift_reg_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [3:0]       rise;
  logic             din_q;
  logic             hold_q,  hold_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             ovr_q,   ovr_d;
  logic             latch_en;
  logic             shift_en;
  logic             complete;
  logic             accept;
`ifdef PHASE_ORDER_CHK_EN
  phase_state_e     state_q, state_d;
  logic             err_q,   err_d;
`else
  logic             unused_rise;
  assign unused_rise = rise[1] ^ rise[3];
`endif

  phase_edge_det u_det_p1 (.clk(clk), .rst(rst), .strobe_i(bus.p1), .rise_o(rise[0]));
  phase_edge_det u_det_p2 (.clk(clk), .rst(rst), .strobe_i(bus.p2), .rise_o(rise[1]));
  phase_edge_det u_det_p3 (.clk(clk), .rst(rst), .strobe_i(bus.p3), .rise_o(rise[2]));
  phase_edge_det u_det_p4 (.clk(clk), .rst(rst), .strobe_i(bus.p4), .rise_o(rise[3]));

  assign complete = (cnt_q == CW'(WIDTH));
  assign accept   = valid_q & bus.word_ready;

  always_comb begin
    hold_d   = hold_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ovr_d    = ovr_q;
    latch_en = 1'b0;
    shift_en = 1'b0;
`ifdef PHASE_ORDER_CHK_EN
    state_d  = state_q;
    err_d    = err_q;
    if (state_q == ST_IDLE) begin
      if (rise[0]) begin
        state_d  = ST_PH1;
        latch_en = 1'b1;
      end
    end else if (rise != 4'b0000) begin
      if (rise == phase_strobe(next_phase(state_q))) begin
        state_d  = next_phase(state_q);
        latch_en = rise[0];
        shift_en = rise[2];
      end else begin
        // Illegal order: abandon the partial word, keep shift register contents
        err_d   = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
        hold_d  = 1'b0;
      end
    end
`else
    latch_en = rise[0];
    shift_en = rise[2];
`endif

    if (latch_en) hold_d = din_q;
    if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], hold_q};
      cnt_d   = cnt_q + CW'(1);
    end

    if (accept) valid_d = 1'b0;
    if (complete) begin
      cnt_d = '0;
      // A word finishing under an unaccepted valid is dropped
      if (!valid_q || accept) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q   <= 1'b0;
      hold_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
`ifdef PHASE_ORDER_CHK_EN
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
`endif
    end else begin
      din_q   <= bus.din;
      hold_q  <= hold_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
`ifdef PHASE_ORDER_CHK_EN
      state_q <= state_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.word_valid = valid_q;
  assign bus.word_data  = data_q;
  assign bus.overrun    = ovr_q;
`ifdef PHASE_ORDER_CHK_EN
  assign bus.phase_err  = err_q;
`else
  assign bus.phase_err  = 1'b0;
`endif
endmodule

// File: tb/tb_phase_shift_reg.sv
// Randomised scoreboard bench for phase_shift_reg (WIDTH=8); the reference model
// works per strobe step and follows PHASE_ORDER_CHK_EN the same way as the RTL build.
module tb_phase_shift_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phase_shift_reg_if #(.WIDTH(8)) bus ();
  phase_shift_reg #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned valid_cycles = 0;

  // Reference model state, advanced once per strobe step
  int          m_state;   // 0 idle, 1..4 = last legal phase seen
  logic        m_hold;
  logic [7:0]  m_sh;
  int          m_cnt;
  logic        m_pend;
  logic [7:0]  m_data;
  logic        m_err;
  logic        m_ovr;
  logic [7:0]  exp_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_hold = 1'b0; m_sh = 8'h00; m_cnt = 0;
    m_pend = 1'b0; m_data = 8'h00; m_err = 1'b0; m_ovr = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic [3:0] m, input logic b, input logic rdy);
    logic do_latch;
    logic do_shift;
    int   nxt;
    do_latch = 1'b0;
    do_shift = 1'b0;
    if (rdy) m_pend = 1'b0;
`ifdef PHASE_ORDER_CHK_EN
    if (m_state == 0) begin
      if (m[0]) begin m_state = 1; do_latch = 1'b1; end
    end else if (m != 4'b0000) begin
      nxt = (m_state % 4) + 1;
      if (m == (4'b0001 << (nxt - 1))) begin
        m_state  = nxt;
        do_latch = (nxt == 1);
        do_shift = (nxt == 3);
      end else begin
        m_err = 1'b1; m_state = 0; m_cnt = 0; m_hold = 1'b0;
      end
    end
`else
    do_latch = m[0];
    do_shift = m[2];
`endif
    if (do_shift) begin
      m_sh = {m_sh[6:0], m_hold};
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (m_pend) m_ovr = 1'b1;
        else begin
          m_data = m_sh;
          exp_q.push_back(m_sh);
          m_pend = 1'b1;
        end
      end
    end
    if (do_latch) m_hold = b;
    if (rdy) m_pend = 1'b0;
  endfunction

  // Scoreboard consumer: every accepted word must be the oldest expected one
  always @(negedge clk) begin
    if (rst && bus.word_valid) valid_cycles++;
    if (rst && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.word_data), 32'hFFFF_FFFF);
      else chk("word_data_handshake", 32'(bus.word_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input logic [3:0] m, input logic b, input logic rdy);
    tick();
    model_step(m, b, rdy);
    bus.word_ready = rdy;
    {bus.p4, bus.p3, bus.p2, bus.p1} = m;
    bus.din = b;
    repeat (2) tick();
    {bus.p4, bus.p3, bus.p2, bus.p1} = 4'b0000;
    repeat (3) tick();
    @(negedge clk);
    chk("word_valid", 32'(bus.word_valid), 32'(m_pend));
    chk("word_data", 32'(bus.word_data), 32'(m_data));
    chk("phase_err", 32'(bus.phase_err), 32'(m_err));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    step(4'b0001, b, rdy);
    step(4'b0010, 1'b0, rdy);
    step(4'b0100, 1'b0, rdy);
    step(4'b1000, 1'b0, rdy);
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) send_bit(w[i], rdy);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    {bus.p4, bus.p3, bus.p2, bus.p1} = 4'b0000;
    bus.din = 1'b0;
    model_reset();
    #1;
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word_data", 32'(bus.word_data), 32'd0);
    chk("rst_phase_err", 32'(bus.phase_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int unsigned vc0;
    int unsigned k;
    logic [3:0]  m;
    logic [7:0]  w;
    bus.p1 = 1'b0; bus.p2 = 1'b0; bus.p3 = 1'b0; bus.p4 = 1'b0;
    bus.din = 1'b0; bus.word_ready = 1'b0;
    do_reset();

    // Single word, consumer always ready: one valid cycle
    vc0 = valid_cycles;
    send_word(8'hA5, 1'b1);
    chk("a5_valid_cycles", valid_cycles - vc0, 32'd1);

    // Consumer stalled across two words: second is dropped
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Out-of-order p4 after p2 mid-word, then a clean word
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    step(4'b0001, 1'b1, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    send_word(8'hFF, 1'b1);

    // Reset mid-word discards partial bits
    do_reset();
    w = 8'h81;
    for (int i = 7; i >= 3; i--) send_bit(w[i], 1'b1);
    do_reset();
    send_word(8'h81, 1'b1);

    // p1 and p3 together while in PH4
    send_bit(1'b1, 1'b1);
    step(4'b0101, 1'b0, 1'b1);
    send_word(8'h96, 1'b1);

    // p1/p3-only sequencing
    do_reset();
    w = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      step(4'b0001, w[i], 1'b1);
      step(4'b0100, 1'b0, 1'b1);
    end

    // Randomised mostly-legal strobes with random backpressure
    do_reset();
    k = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) < 8) m = 4'($urandom_range(15));
      else begin
        m = 4'b0001 << k;
        k = (k + 1) % 4;
      end
      step(m, 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
    end

    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("expected_words_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/phase_shift_reg.md
PHASE_SHIFT_REG -- requirements
Module: phase_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, deserialised word width (2..32).
REQ-002 clk  in  1  single system clock; all state on posedge clk.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 p1, p2, p3, p4  in  1 each  four-phase strobes from the upstream clock divider, sampled on clk.
REQ-005 din  in  1  serial data, valid while p1 high.
REQ-006 word_ready  in  1  consumer accepts word_data.
REQ-007 word_valid  out  1  word_data holds a complete word.
REQ-008 word_data  out  WIDTH  deserialised word, MSB first.
REQ-009 phase_err  out  1  sticky illegal-phase-order flag.
REQ-010 overrun  out  1  sticky dropped-word flag.

Function
REQ-011 Each strobe SHALL pass through one sampling flop; a rise SHALL be detected as sampled=1 with the previous sample=0, one cycle after first sampling.
REQ-012 On a p1 rise, din (sampled with p1) SHALL be latched into a hold bit.
REQ-013 On a p3 rise, the shift register SHALL shift left with the hold bit entering at bit 0, and the bit counter SHALL increment.
REQ-014 FSM states: IDLE, PH1, PH2, PH3, PH4.
- IDLE->PH1 on p1 rise.
- PH1->PH2 on p2 rise; PH2->PH3 on p3 rise; PH3->PH4 on p4 rise; PH4->PH1 on p1 rise.
REQ-015 In IDLE, rises of p2/p3/p4 SHALL be ignored, with no shift and no error.
REQ-016 A rise other than the expected next phase, or two or more rises in one cycle, SHALL be illegal outside IDLE. Response: phase_err set, FSM->IDLE, bit counter cleared, hold discarded, shift register unchanged.
REQ-017 When the counter reaches WIDTH on a p3 rise, the next clk SHALL load word_data with the full shift register, assert word_valid and clear the counter.
REQ-018 word_valid SHALL stay high until a cycle with word_valid=1 and word_ready=1; it deasserts the following cycle.
REQ-019 A word completing while word_valid=1 and word_ready=0 SHALL be dropped: word_data is unchanged and overrun is set.
REQ-020 A completion in the same cycle as an accepting handshake SHALL load the new word and keep word_valid high, with no overrun.
REQ-021 phase_err and overrun SHALL clear only on reset.

Reset
REQ-022 While rst=0, the block SHALL be forced as follows:
- state=IDLE
- sampled strobes, hold, shift register and counter = 0
- word_valid=0, word_data=0, phase_err=0, overrun=0
REQ-023 A reset asserted mid-word SHALL discard all partial bits.
REQ-024 After rst deasserts, the first p1 rise SHALL be detected only if p1 was sampled 0 at least once after release.

Configuration
REQ-025 Macro PHASE_ORDER_CHK_EN:
- Defined: REQ-014..REQ-016 apply.
- Undefined: no FSM; p1 rise latches and p3 rise shifts in any order; phase_err is tied 0.

Structure
REQ-026 Package phase_pkg SHALL hold the FSM state enum and the WIDTH default constant.
REQ-027 Sub-module phase_edge_det (sampling flop plus rise detect, one instance per strobe) SHALL be used.

Verification
REQ-028 WIDTH=8, legal 1-2-3-4 cycles carrying 0xA5 MSB first, word_ready=1 -> word_data=0xA5, word_valid high for one cycle, no flags.
REQ-029 Two words 0x3C then 0xC3 with word_ready=0 throughout -> word_data=0x3C, word_valid held, overrun=1.
REQ-030 After 3 legal bits, p4 rises directly after p2 -> phase_err=1, counter=0; the next 8 legal bits 0xFF -> word_data=0xFF.
REQ-031 rst pulsed low after 5 bits of 0x81 -> all outputs 0; a following full 0x81 -> word_data=0x81.
REQ-032 p1 and p3 rise in the same cycle while in PH4 -> phase_err=1, FSM=IDLE, no shift.
REQ-033 Build without PHASE_ORDER_CHK_EN, order p1-p3 only ×8 carrying 0x5A -> word_data=0x5A, phase_err=0.
